// File: rtl/demux_1x16_if.sv
// demux_1x16_if: bit-stream input, lane control and assembled-word handshake for demux_1x16
interface demux_1x16_if;
    logic        in_valid;
    logic        in_ready;
    logic        d_in;
    logic [3:0]  sel;
    logic        auto;
    logic        clear;
    logic [15:0] a_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] wr_strobe;
    logic [3:0]  ptr;
    logic        dup;
    modport master (
        output in_valid, d_in, sel, auto, clear, out_ready,
        input  in_ready, a_out, out_valid, wr_strobe, ptr, dup
    );
    modport slave (
        input  in_valid, d_in, sel, auto, clear, out_ready,
        output in_ready, a_out, out_valid, wr_strobe, ptr, dup
    );
endinterface

// File: rtl/demux_1x16.sv
// demux_1x16: registered 1:16 bit demux that assembles a 16-bit word and publishes it once every lane is written
module demux_1x16 (
    input logic        clk,
    input logic        rst,
    demux_1x16_if.slave bus
);
    logic [15:0] stage, mask, onehot, next_stage;
    logic [3:0]  idx;
    logic        wr, done;
    assign bus.in_ready = !bus.out_valid | bus.out_ready;
    assign idx          = bus.auto ? bus.ptr : bus.sel;
    assign onehot       = 16'd1 << idx;
    // clear wins over a same-cycle accept, so the offered bit is dropped
    assign wr           = bus.in_valid & bus.in_ready & !bus.clear;
    assign done         = wr & ((mask | onehot) == 16'hFFFF);
    assign next_stage   = (stage & ~onehot) | ({16{bus.d_in}} & onehot);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage         <= '0;
            mask          <= '0;
            bus.ptr       <= '0;
            bus.a_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.wr_strobe <= '0;
            bus.dup       <= 1'b0;
        end else begin
            if (bus.clear) begin
                stage   <= '0;
                mask    <= '0;
                bus.ptr <= '0;
            end else if (wr) begin
                stage   <= next_stage;
                mask    <= done ? 16'd0 : (mask | onehot);
                bus.ptr <= done ? 4'd0 : (bus.auto ? bus.ptr + 4'd1 : bus.ptr);
            end
            bus.wr_strobe <= wr ? onehot : 16'd0;
            bus.dup       <= wr & mask[idx];
            if (done) begin
                bus.a_out     <= next_stage;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_demux_1x16.sv
// tb_demux_1x16: directed self-checking bench for demux_1x16
module tb_demux_1x16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [15:0] word;
    demux_1x16_if bus();
    demux_1x16 dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_a_out"}, bus.a_out, 16'h0);
        chk({tag, "_out_valid"}, {15'd0, bus.out_valid}, 16'h0);
        chk({tag, "_wr_strobe"}, bus.wr_strobe, 16'h0);
        chk({tag, "_ptr"}, {12'd0, bus.ptr}, 16'h0);
        chk({tag, "_dup"}, {15'd0, bus.dup}, 16'h0);
        chk({tag, "_in_ready"}, {15'd0, bus.in_ready}, 16'h1);
    endtask
    initial begin
        bus.in_valid = 0; bus.d_in = 0; bus.sel = 0; bus.auto = 1; bus.clear = 0; bus.out_ready = 1;
        #3;
        chk_reset("rst");
        step; step;
        rst = 0;
        // auto stream 0xA5C3 LSB first
        word = 16'hA5C3;
        bus.in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            bus.d_in = word[i];
            step;
            chk("t1_strobe", bus.wr_strobe, 16'd1 << i);
            chk("t1_dup", {15'd0, bus.dup}, 16'h0);
            chk("t1_ptr", {12'd0, bus.ptr}, (i == 15) ? 16'd0 : 16'(i + 1));
            chk("t1_valid", {15'd0, bus.out_valid}, (i == 15) ? 16'd1 : 16'd0);
        end
        chk("t1_a_out", bus.a_out, 16'hA5C3);
        bus.in_valid = 0;
        step;
        chk("t1_valid_drop", {15'd0, bus.out_valid}, 16'h0);
        // explicit select 15..0, ones on odd lanes
        bus.auto = 0; bus.in_valid = 1;
        for (int i = 15; i >= 0; i--) begin
            bus.sel = 4'(i);
            bus.d_in = i[0];
            step;
            chk("t2_dup", {15'd0, bus.dup}, 16'h0);
            chk("t2_strobe", bus.wr_strobe, 16'd1 << i);
        end
        chk("t2_valid", {15'd0, bus.out_valid}, 16'h1);
        chk("t2_a_out", bus.a_out, 16'hAAAA);
        bus.in_valid = 0;
        step;
        // lane 3 overwrite
        bus.in_valid = 1; bus.sel = 3; bus.d_in = 1;
        step;
        chk("t3_dup_first", {15'd0, bus.dup}, 16'h0);
        bus.d_in = 0;
        step;
        chk("t3_dup_second", {15'd0, bus.dup}, 16'h1);
        chk("t3_valid_early", {15'd0, bus.out_valid}, 16'h0);
        bus.d_in = 1;
        for (int i = 0; i < 16; i++) begin
            if (i != 3) begin
                bus.sel = 4'(i);
                step;
                chk("t3_dup", {15'd0, bus.dup}, 16'h0);
                chk("t3_valid", {15'd0, bus.out_valid}, (i == 15) ? 16'd1 : 16'd0);
            end
        end
        chk("t3_a_out", bus.a_out, 16'hFFF7);
        bus.in_valid = 0;
        step;
        // completion under backpressure
        bus.auto = 1; bus.out_ready = 0; bus.in_valid = 1;
        word = 16'h5A5A;
        for (int i = 0; i < 16; i++) begin
            bus.d_in = word[i];
            step;
        end
        chk("t4_valid", {15'd0, bus.out_valid}, 16'h1);
        chk("t4_a_out", bus.a_out, 16'h5A5A);
        chk("t4_in_ready", {15'd0, bus.in_ready}, 16'h0);
        bus.d_in = 1;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("t4_hold_ready", {15'd0, bus.in_ready}, 16'h0);
            chk("t4_hold_ptr", {12'd0, bus.ptr}, 16'h0);
            chk("t4_hold_strobe", bus.wr_strobe, 16'h0);
            chk("t4_hold_a_out", bus.a_out, 16'h5A5A);
            chk("t4_hold_valid", {15'd0, bus.out_valid}, 16'h1);
        end
        bus.out_ready = 1;
        step;
        chk("t4_consumed", {15'd0, bus.out_valid}, 16'h0);
        chk("t4_ready_back", {15'd0, bus.in_ready}, 16'h1);
        chk("t4_lane0", bus.wr_strobe, 16'h0001);
        chk("t4_ptr", {12'd0, bus.ptr}, 16'h1);
        // six more writes make seven, then clear with in_valid
        for (int i = 0; i < 6; i++) step;
        chk("t5_ptr7", {12'd0, bus.ptr}, 16'h7);
        bus.clear = 1;
        step;
        chk("t5_ptr", {12'd0, bus.ptr}, 16'h0);
        chk("t5_strobe", bus.wr_strobe, 16'h0);
        chk("t5_dup", {15'd0, bus.dup}, 16'h0);
        chk("t5_valid", {15'd0, bus.out_valid}, 16'h0);
        bus.clear = 0;
        word = 16'h1234;
        for (int i = 0; i < 16; i++) begin
            bus.d_in = word[i];
            step;
            chk("t5_dup_frame", {15'd0, bus.dup}, 16'h0);
            chk("t5_valid_frame", {15'd0, bus.out_valid}, (i == 15) ? 16'd1 : 16'd0);
        end
        chk("t5_a_out", bus.a_out, 16'h1234);
        // asynchronous reset mid-frame
        bus.d_in = 1;
        for (int i = 0; i < 5; i++) step;
        chk("t6_ptr5", {12'd0, bus.ptr}, 16'h5);
        bus.in_valid = 0;
        #2 rst = 1;
        #1;
        chk_reset("t6_async");
        step;
        rst = 0;
        bus.in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            step;
            chk("t6_dup", {15'd0, bus.dup}, 16'h0);
            chk("t6_valid", {15'd0, bus.out_valid}, (i == 15) ? 16'd1 : 16'd0);
        end
        chk("t6_a_out", bus.a_out, 16'hFFFF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
